// File: rtl/fp_pkg.sv
// fp_pkg
// Definitions shared by the single-precision compare/select unit:
//   - operation encodings carried on the 3-bit op port
//   - FSM state encoding
//   - default canonical NaN and the binary32 exponent all-ones pattern
//   - FCLASS one-hot bit indices
//   - the order-preserving compare key helper
package fp_pkg;

    typedef enum logic [2:0] {
        OP_FMIN   = 3'b000,
        OP_FMAX   = 3'b001,
        OP_FEQ    = 3'b010,
        OP_FLT    = 3'b011,
        OP_FLE    = 3'b100,
        OP_FCLASS = 3'b101
    } fp_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HOLD   = 2'd3
    } fp_state_e;

    localparam logic [31:0] CANON_NAN_DEFAULT = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_ALL_ONES      = 8'hFF;

    localparam int CLS_W         = 10;
    localparam int CLS_NEG_INF   = 0;
    localparam int CLS_NEG_NORM  = 1;
    localparam int CLS_NEG_SUB   = 2;
    localparam int CLS_NEG_ZERO  = 3;
    localparam int CLS_POS_ZERO  = 4;
    localparam int CLS_POS_SUB   = 5;
    localparam int CLS_POS_NORM  = 6;
    localparam int CLS_POS_INF   = 7;
    localparam int CLS_SNAN      = 8;
    localparam int CLS_QNAN      = 9;

    // Maps a binary32 pattern onto an unsigned key whose ordering matches
    // the numeric ordering for non-NaN values. Positive values get the top
    // bit set; negative values are bit-inverted so larger magnitudes sort
    // lower. -0 maps just below +0, which is exactly the FMIN/FMAX order.
    function automatic logic [31:0] cmp_key(input logic [31:0] x);
        return x[31] ? ~x : {1'b1, x[30:0]};
    endfunction

endpackage

// File: rtl/fp_classify.sv
// fp_classify
// Combinational binary32 classifier producing the RISC-V FCLASS one-hot.
// Ports:
//   x_i   [31:0]  binary32 operand
//   cls_o [9:0]   one-hot class (bit map as in fp_pkg CLS_* indices)
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0]      x_i,
    output logic [CLS_W-1:0] cls_o
);

    logic        sign;
    logic [7:0]  exp_f;
    logic [22:0] man_f;

    assign sign  = x_i[31];
    assign exp_f = x_i[30:23];
    assign man_f = x_i[22:0];

    always_comb begin
        cls_o = '0;
        if (exp_f == EXP_ALL_ONES) begin
            if (man_f == '0) begin
                cls_o[sign ? CLS_NEG_INF : CLS_POS_INF] = 1'b1;
            end else if (man_f[22]) begin
                cls_o[CLS_QNAN] = 1'b1;
            end else begin
                cls_o[CLS_SNAN] = 1'b1;
            end
        end else if (exp_f == 8'h00) begin
            if (man_f == '0) begin
                cls_o[sign ? CLS_NEG_ZERO : CLS_POS_ZERO] = 1'b1;
            end else begin
                cls_o[sign ? CLS_NEG_SUB : CLS_POS_SUB] = 1'b1;
            end
        end else begin
            cls_o[sign ? CLS_NEG_NORM : CLS_POS_NORM] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_cmp_unit.sv
// fp_cmp_unit
// Multi-cycle binary32 compare/select unit: FMIN, FMAX, FEQ, FLT, FLE, FCLASS
// with RISC-V NaN semantics and invalid-operation flag.
// Flow: IDLE (accept) -> DECODE (classify, build keys) -> EXEC (result)
//       -> HOLD (result_valid until result_ack).
// Ports:
//   clk           system clock
//   resetn        synchronous reset, active high
//   start         request, taken only while ready
//   op [2:0]      operation select (110/111 produce zero, no flag)
//   rs1, rs2      binary32 operands (rs2 unused by FCLASS)
//   ready         high only in IDLE
//   result_valid  high in HOLD
//   result [31:0] FP result or zero-extended integer result
//   fflag_nv      invalid-operation flag for the held result
//   result_ack    consumer takes the result while result_valid
module fp_cmp_unit
    import fp_pkg::*;
#(
    parameter logic [31:0] CANON_NAN = CANON_NAN_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        ready,
    output logic        result_valid,
    output logic [31:0] result,
    output logic        fflag_nv,
    input  logic        result_ack
);

    fp_state_e        state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic [CLS_W-1:0] cls_a_q, cls_a_d, cls_b_q, cls_b_d;
    logic [31:0]      key_a_q, key_a_d, key_b_q, key_b_d;
    logic [31:0]      result_q, result_d;
    logic             nv_q, nv_d;

    // One classifier per latched operand.
    logic [31:0]      opnd [2];
    logic [CLS_W-1:0] cls  [2];

    assign opnd[0] = a_q;
    assign opnd[1] = b_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cls
            fp_classify u_cls (
                .x_i   (opnd[gi]),
                .cls_o (cls[gi])
            );
        end
    endgenerate

    // Execute-stage datapath, working only from DECODE registers.
    logic        a_nan, b_nan, a_snan, b_snan, any_nan, any_snan;
    logic        both_zero, a_lt_b, keys_eq;
    logic [31:0] exec_result;
    logic        exec_nv;

    assign a_snan    = cls_a_q[CLS_SNAN];
    assign b_snan    = cls_b_q[CLS_SNAN];
    assign a_nan     = a_snan | cls_a_q[CLS_QNAN];
    assign b_nan     = b_snan | cls_b_q[CLS_QNAN];
    assign any_nan   = a_nan | b_nan;
    assign any_snan  = a_snan | b_snan;
    assign both_zero = (cls_a_q[CLS_NEG_ZERO] | cls_a_q[CLS_POS_ZERO]) &
                       (cls_b_q[CLS_NEG_ZERO] | cls_b_q[CLS_POS_ZERO]);
    assign a_lt_b    = key_a_q < key_b_q;
    assign keys_eq   = key_a_q == key_b_q;

    always_comb begin
        exec_result = '0;
        exec_nv     = 1'b0;
        case (op_q)
            OP_FMIN, OP_FMAX: begin
                exec_nv = any_snan;
                if (a_nan && b_nan) begin
                    exec_result = CANON_NAN;
                end else if (a_nan) begin
                    exec_result = b_q;
                end else if (b_nan) begin
                    exec_result = a_q;
                end else if (op_q == OP_FMIN) begin
                    // Key order already places -0 below +0.
                    exec_result = a_lt_b ? a_q : b_q;
                end else begin
                    exec_result = a_lt_b ? b_q : a_q;
                end
            end
            OP_FEQ: begin
                // Quiet compare: only signalling NaNs raise NV.
                exec_nv        = any_snan;
                exec_result[0] = !any_nan && (both_zero || keys_eq);
            end
            OP_FLT: begin
                // Signalling compare: any NaN raises NV.
                exec_nv        = any_nan;
                exec_result[0] = !any_nan && !both_zero && a_lt_b;
            end
            OP_FLE: begin
                exec_nv        = any_nan;
                exec_result[0] = !any_nan && (both_zero || a_lt_b || keys_eq);
            end
            OP_FCLASS: begin
                exec_result[CLS_W-1:0] = cls_a_q;
            end
            default: begin
                exec_result = '0;
                exec_nv     = 1'b0;
            end
        endcase
    end

    // Next-state and register-enable logic.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cls_a_d  = cls_a_q;
        cls_b_d  = cls_b_q;
        key_a_d  = key_a_q;
        key_b_d  = key_b_q;
        result_d = result_q;
        nv_d     = nv_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = rs1;
                    b_d     = rs2;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                cls_a_d = cls[0];
                cls_b_d = cls[1];
                key_a_d = cmp_key(a_q);
                key_b_d = cmp_key(b_q);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                result_d = exec_result;
                nv_d     = exec_nv;
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                // result stays as last value after ack; the flag does not.
                if (result_ack) begin
                    nv_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cls_a_q  <= '0;
            cls_b_q  <= '0;
            key_a_q  <= '0;
            key_b_q  <= '0;
            result_q <= '0;
            nv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cls_a_q  <= cls_a_d;
            cls_b_q  <= cls_b_d;
            key_a_q  <= key_a_d;
            key_b_q  <= key_b_d;
            result_q <= result_d;
            nv_q     <= nv_d;
        end
    end

    assign ready        = (state_q == ST_IDLE);
    assign result_valid = (state_q == ST_HOLD);
    assign result       = result_q;
    assign fflag_nv     = nv_q;

endmodule

// File: tb/tb_fp_cmp_unit.sv
// tb_fp_cmp_unit
// Scoreboard bench for fp_cmp_unit: expected results are queued when a
// request is driven and compared when result_valid is seen. Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_fp_cmp_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1, rs2;
    logic        ready;
    logic        result_valid;
    logic [31:0] result;
    logic        fflag_nv;
    logic        result_ack;

    localparam logic [2:0] FMIN = 3'b000, FMAX = 3'b001, FEQ = 3'b010,
                           FLT = 3'b011, FLE = 3'b100, FCLS = 3'b101;

    typedef struct {
        logic [31:0] res;
        logic        nv;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    fp_cmp_unit dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .op           (op),
        .rs1          (rs1),
        .rs2          (rs2),
        .ready        (ready),
        .result_valid (result_valid),
        .result       (result),
        .fflag_nv     (fflag_nv),
        .result_ack   (result_ack)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    // Issue one op, wait for its result, compare against the scoreboard,
    // then acknowledge and confirm the unit is ready again.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic en,
                          input bit ack_early);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (!ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!ready) begin
            check_eq({tag, "_ready_timeout"}, 32'(ready), 32'd1);
            return;
        end
        op    = o;
        rs1   = a;
        rs2   = b;
        start = 1'b1;
        if (ack_early) result_ack = 1'b1;
        e.res = er;
        e.nv  = en;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!result_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!result_valid) begin
            check_eq({tag, "_valid_timeout"}, 32'(result_valid), 32'd1);
            sb.delete();
            result_ack = 1'b0;
            return;
        end
        check_eq({tag, "_latency"}, 32'(cyc), 32'd3);
        e = sb.pop_front();
        check_eq({tag, "_result"}, result, e.res);
        check_eq({tag, "_nv"}, 32'(fflag_nv), 32'(e.nv));
        $display("op=%0d rs1=%08h rs2=%08h -> result=%08h nv=%0d (%s)",
                 o, a, b, result, fflag_nv, tag);
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        check_eq({tag, "_ready_after_ack"}, 32'(ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [31:0] held;
        resetn     = 1'b1;
        start      = 1'b0;
        op         = '0;
        rs1        = '0;
        rs2        = '0;
        result_ack = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_valid", 32'(result_valid), 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_nv", 32'(fflag_nv), 32'd0);

        // Latency with ack held high throughout.
        run_op("fmin_lat", FMIN, 32'h3F800000, 32'hC0000000, 32'hC0000000, 1'b0, 1'b1);

        // Signed zero and NaN selection.
        run_op("fmax_zero", FMAX, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0, 1'b0);
        run_op("fmin_zero", FMIN, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0);
        run_op("fmax_qnan", FMAX, 32'h7FC00000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
        run_op("fmin_2snan", FMIN, 32'h7F800001, 32'h7F800002, 32'h7FC00000, 1'b1, 1'b0);
        run_op("fmax_snan", FMAX, 32'h7F800001, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0);
        run_op("fmin_bqnan", FMIN, 32'h3F800000, 32'h7FC00000, 32'h3F800000, 1'b0, 1'b0);
        run_op("fmax_neg", FMAX, 32'hC0000000, 32'hBF800000, 32'hBF800000, 1'b0, 1'b0);
        run_op("fmin_neg", FMIN, 32'hC0000000, 32'hBF800000, 32'hC0000000, 1'b0, 1'b0);

        // Compares.
        run_op("feq_qnan", FEQ, 32'h7FC00000, 32'h3F800000, 32'd0, 1'b0, 1'b0);
        run_op("flt_qnan", FLT, 32'h7FC00000, 32'h3F800000, 32'd0, 1'b1, 1'b0);
        run_op("feq_snan", FEQ, 32'h7F800001, 32'h3F800000, 32'd0, 1'b1, 1'b0);
        run_op("feq_zero", FEQ, 32'h00000000, 32'h80000000, 32'd1, 1'b0, 1'b0);
        run_op("fle_neg", FLE, 32'hBF800000, 32'h3F800000, 32'd1, 1'b0, 1'b0);
        run_op("flt_eq", FLT, 32'h3F800000, 32'h3F800000, 32'd0, 1'b0, 1'b0);
        run_op("fle_eq", FLE, 32'h3F800000, 32'h3F800000, 32'd1, 1'b0, 1'b0);
        run_op("flt_neg", FLT, 32'hC0000000, 32'hBF800000, 32'd1, 1'b0, 1'b0);
        run_op("flt_zero", FLT, 32'h80000000, 32'h00000000, 32'd0, 1'b0, 1'b0);
        run_op("fle_gt", FLE, 32'h40000000, 32'h3F800000, 32'd0, 1'b0, 1'b0);

        // Classification.
        run_op("fcls_ninf", FCLS, 32'hFF800000, 32'h0, 32'h00000001, 1'b0, 1'b0);
        run_op("fcls_psub", FCLS, 32'h00000001, 32'h0, 32'h00000020, 1'b0, 1'b0);
        run_op("fcls_snan", FCLS, 32'h7F800001, 32'h0, 32'h00000100, 1'b0, 1'b0);
        run_op("fcls_qnan", FCLS, 32'h7FC00000, 32'h0, 32'h00000200, 1'b0, 1'b0);
        run_op("fcls_nzero", FCLS, 32'h80000000, 32'h0, 32'h00000008, 1'b0, 1'b0);
        run_op("fcls_nsub", FCLS, 32'h807FFFFF, 32'h0, 32'h00000004, 1'b0, 1'b0);
        run_op("fcls_nnorm", FCLS, 32'hBF800000, 32'h0, 32'h00000002, 1'b0, 1'b0);
        run_op("fcls_pnorm", FCLS, 32'h00800000, 32'h0, 32'h00000040, 1'b0, 1'b0);
        run_op("fcls_pinf", FCLS, 32'h7F800000, 32'h0, 32'h00000080, 1'b0, 1'b0);
        run_op("illegal", 3'b110, 32'h3F800000, 32'h7F800001, 32'd0, 1'b0, 1'b0);

        // Held result: no ack for 5 cycles, stray start ignored.
        op    = FMIN;
        rs1   = 32'h7F800001;
        rs2   = 32'h40400000;
        start = 1'b1;
        e.res = 32'h40400000;
        e.nv  = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("hold_valid", 32'(result_valid), 32'd1);
        e = sb.pop_front();
        held = e.res;
        for (int i = 0; i < 5; i++) begin
            check_eq("hold_result", result, e.res);
            check_eq("hold_nv", 32'(fflag_nv), 32'(e.nv));
            check_eq("hold_valid_stay", 32'(result_valid), 32'd1);
            if (i == 2) begin
                op    = FMAX;
                rs1   = 32'h41000000;
                rs2   = 32'h42000000;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        $display("hold: result=%08h nv=%0d held 5 cycles", result, fflag_nv);
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_eq("post_ack_no_valid", 32'(result_valid), 32'd0);
            check_eq("post_ack_result_kept", result, held);
            check_eq("post_ack_nv_clear", 32'(fflag_nv), 32'd0);
            @(negedge clk);
        end

        run_op("after_hold", FMAX, 32'h3F800000, 32'h40000000, 32'h40000000, 1'b0, 1'b0);

        // Reset while in DECODE.
        op    = FMAX;
        rs1   = 32'h3F800000;
        rs2   = 32'h40800000;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        check_eq("midrst_ready", 32'(ready), 32'd1);
        check_eq("midrst_valid", 32'(result_valid), 32'd0);
        check_eq("midrst_result", result, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("midrst_no_stale", 32'(result_valid), 32'd0);
        end
        $display("mid-op reset: ready=%0d valid=%0d result=%08h", ready, result_valid, result);

        run_op("after_rst", FLE, 32'hC0000000, 32'hC0000000, 32'd1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_cmp_unit.md
Name: fp_cmp_unit

Overview:
- Multi-cycle single-precision compare/select unit for the F-extension datapath.
- Covers FMIN, FMAX, FEQ, FLT, FLE and FCLASS with full RISC-V NaN semantics and an invalid (NV) flag.
- FMIN and FLT/FLE/FEQ are the select and integer-result counterparts of the existing max path.
- Sits beside the FPU execute stage. Integer-result ops (FEQ/FLT/FLE/FCLASS) return to the integer writeback path; FMIN/FMAX return to the FP register file.
- Uses a start / result_valid / result_ack handshake with a held output buffer.

Parameters:
- CANON_NAN, 32'h7FC00000, value returned when both FMIN/FMAX operands are NaN.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- resetn  input  1  reset; synchronous, active-high (asserted = 1).
- start  input  1  request; accepted only in a cycle where ready = 1.
- op  input  3  000 FMIN, 001 FMAX, 010 FEQ, 011 FLT, 100 FLE, 101 FCLASS, 110/111 illegal.
- rs1  input  32  operand A, IEEE-754 binary32.
- rs2  input  32  operand B (ignored for FCLASS).
- ready  output  1  high only in IDLE.
- result_valid  output  1  result and fflag_nv are valid; held until acknowledged.
- result  output  32  FP result, or zero-extended integer result.
- fflag_nv  output  1  invalid-operation flag for this result.
- result_ack  input  1  consumer takes the result.

Behaviour:
- Reset (resetn = 1 at a clock edge), from any state:
  - state = IDLE, ready = 1, result_valid = 0, result = 0, fflag_nv = 0.
  - Any in-flight op is discarded.
- FSM states: IDLE, DECODE, EXEC, HOLD.
- IDLE:
  - start = 1 at edge T latches op, rs1 and rs2; go to DECODE.
  - ready = 0 from T+1.
- DECODE: register the 10-bit class of each operand and the sign/magnitude compare keys; go to EXEC.
- EXEC: compute and register result and fflag_nv; go to HOLD.
- HOLD:
  - result_valid = 1 starting at T+3, i.e. the cycle after EXEC.
  - result and fflag_nv are stable while result_valid = 1.
  - result_ack = 1 at an edge: return to IDLE, result_valid = 0. result keeps its value; fflag_nv clears to 0.
- Latency and throughput:
  - Minimum latency is 3 cycles from accept to result_valid.
  - Next accept is possible no earlier than the cycle after ack.
- start while ready = 0 is ignored (no queueing).
- result_ack outside HOLD is ignored.
- Ordering: use the sign-flipped magnitude key. For negative operands invert magnitude ordering. Treat -0 < +0 for FMIN/FMAX only.
- NaN handling:
  - sNaN = exponent all ones, mantissa != 0, bit22 = 0.
  - qNaN = exponent all ones, bit22 = 1.
- FMIN / FMAX:
  - One NaN operand: return the other operand.
  - Both NaN: return CANON_NAN.
  - NV = 1 if either operand is sNaN.
- FEQ:
  - Result 1 if equal; +0 == -0.
  - Result 0 if either operand is NaN.
  - NV = 1 only for sNaN.
- FLT / FLE:
  - +0 and -0 compare equal.
  - Result 0 if either operand is NaN, and NV = 1 for any NaN.
- FCLASS:
  - result[9:0] is one-hot; result[31:10] = 0; NV = 0.
  - Bit map: 0 -inf, 1 -normal, 2 -subnormal, 3 -0, 4 +0, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN.
- Illegal op: result = 0, NV = 0, normal handshake.
- Integer results (FEQ/FLT/FLE) are in bit 0, upper 31 bits zero.

Decomposition:
- Package fp_pkg:
  - op encodings, FSM state encoding.
  - CANON_NAN default.
  - FCLASS bit indices, exponent-all-ones constant.
- Sub-module fp_classify:
  - Combinational, 32-bit in, 10-bit one-hot class out.
  - Instanced twice, once per operand, feeding the DECODE registers.

Test Plan:
- FMIN rs1 = 3F800000, rs2 = C0000000, start at T, ack held high:
  - result_valid first seen at T+3, result = C0000000, NV = 0.
  - ready back to 1 at T+4.
- Signed zero and NaN select:
  - FMAX 00000000 vs 80000000 -> 00000000.
  - FMIN same pair -> 80000000.
  - FMAX 7FC00000 vs 3F800000 -> 3F800000, NV = 0.
  - FMIN 7F800001 vs 7F800002 -> 7FC00000, NV = 1.
- Compares:
  - FEQ 7FC00000 vs 3F800000 -> 0, NV = 0.
  - FLT same pair -> 0, NV = 1.
  - FEQ 00000000 vs 80000000 -> 1.
  - FLE BF800000 vs 3F800000 -> 1.
  - FLT 3F800000 vs 3F800000 -> 0.
- FCLASS:
  - FF800000 -> 00000001.
  - 00000001 -> 00000020.
  - 7F800001 -> 00000100.
  - 7FC00000 -> 00000200.
  - 80000000 -> 00000008.
- Handshake:
  - Hold result_ack = 0 for 5 cycles in HOLD; pulse start with new operands.
  - result stays stable, start is ignored, no second result after ack.
- Reset mid-op: assert resetn = 1 during DECODE -> next cycle ready = 1, result_valid = 0, result = 0; no stale result appears.
